// File: rtl/decoder_stage_controller_pkg.sv
// Stage encodings shared by the controller, processing elements and neighbor links.
package decoder_stage_controller_pkg;

   localparam int STAGE_WIDTH = 3;

   typedef enum logic [STAGE_WIDTH-1:0] {
      STAGE_IDLE                = 3'd0,
      STAGE_MEASUREMENT_LOADING = 3'd1,
      STAGE_GROW                = 3'd2,
      STAGE_MERGE               = 3'd3,
      STAGE_PEELING             = 3'd4,
      STAGE_RESULT_VALID        = 3'd5
   } stage_e;

endpackage

// File: rtl/decoder_stage_controller_merge_settle_detector.sv
// Counts consecutive idle grid cycles; settled_o flags the cycle that completes the run.
module merge_settle_detector #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic busy_i,
   output logic settled_o
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Settled combinationally so the merge ends on exactly the Nth idle cycle.
   assign settled_o = !busy_i && (cnt_q >= CNT_W'(SETTLE_CYCLES - 1));

   // Next idle-run count.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || busy_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (!settled_o) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Idle-run count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/decoder_stage_controller.sv
// Round sequencer for the union-find grid: load, alternate merge/grow while odd
// clusters remain, peel, then hold the result until it is consumed.
module decoder_stage_controller
   import decoder_stage_controller_pkg::*;
#(
   parameter int LOAD_CYCLES         = 1,
   parameter int MERGE_SETTLE_CYCLES = 2,
   parameter int PEEL_CYCLES         = 4,
   parameter int MAX_ITERATIONS      = 255,
   parameter int ITER_WIDTH          = 8,
   parameter int CYCLE_WIDTH         = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   new_round_valid,
   output logic                   new_round_ready,
   output logic [STAGE_WIDTH-1:0] global_stage,
   input  logic                   busy,
   input  logic                   odd_clusters,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [ITER_WIDTH-1:0]  iteration_count,
   output logic [CYCLE_WIDTH-1:0] cycle_count,
   output logic                   timeout
);

   localparam int DUR_MAX = (LOAD_CYCLES > PEEL_CYCLES) ? LOAD_CYCLES : PEEL_CYCLES;
   localparam int DUR_W   = $clog2(DUR_MAX + 1);

   stage_e                 state_q, state_d;
   logic [DUR_W-1:0]       dur_q, dur_d;
   logic [ITER_WIDTH-1:0]  iter_q, iter_d;
   logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
   logic                   timeout_q, timeout_d;
   logic                   settled_s;

   merge_settle_detector #(
      .SETTLE_CYCLES(MERGE_SETTLE_CYCLES)
   ) u_settle (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (state_q != STAGE_MERGE),
      .busy_i   (busy),
      .settled_o(settled_s)
   );

   // Next stage and round counters.
   always_comb begin
      state_d   = state_q;
      dur_d     = dur_q;
      iter_d    = iter_q;
      cycle_d   = cycle_q;
      timeout_d = timeout_q;
      if ((state_q inside {STAGE_MEASUREMENT_LOADING, STAGE_MERGE, STAGE_GROW, STAGE_PEELING})
          && (cycle_q != {CYCLE_WIDTH{1'b1}})) begin
         cycle_d = cycle_q + {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         cycle_d = cycle_q;
      end
      case (state_q)
         STAGE_IDLE: begin
            iter_d    = {ITER_WIDTH{1'b0}};
            cycle_d   = {CYCLE_WIDTH{1'b0}};
            timeout_d = 1'b0;
            dur_d     = {DUR_W{1'b0}};
            if (new_round_valid) begin
               state_d = STAGE_MEASUREMENT_LOADING;
            end else begin
               state_d = STAGE_IDLE;
            end
         end
         STAGE_MEASUREMENT_LOADING: begin
            if (dur_q >= DUR_W'(LOAD_CYCLES - 1)) begin
               dur_d   = {DUR_W{1'b0}};
               state_d = STAGE_MERGE;
            end else begin
               dur_d   = dur_q + {{(DUR_W-1){1'b0}}, 1'b1};
            end
         end
         STAGE_MERGE: begin
            if (settled_s) begin
               if (!odd_clusters) begin
                  state_d = STAGE_PEELING;
               end else if (iter_q < ITER_WIDTH'(MAX_ITERATIONS)) begin
                  state_d = STAGE_GROW;
               end else begin
                  timeout_d = 1'b1;
                  state_d   = STAGE_PEELING;
               end
            end else begin
               state_d = STAGE_MERGE;
            end
         end
         STAGE_GROW: begin
            iter_d  = iter_q + {{(ITER_WIDTH-1){1'b0}}, 1'b1};
            state_d = STAGE_MERGE;
         end
         STAGE_PEELING: begin
            if (dur_q >= DUR_W'(PEEL_CYCLES - 1)) begin
               dur_d   = {DUR_W{1'b0}};
               state_d = STAGE_RESULT_VALID;
            end else begin
               dur_d   = dur_q + {{(DUR_W-1){1'b0}}, 1'b1};
            end
         end
         STAGE_RESULT_VALID: begin
            if (result_ready) begin
               state_d = STAGE_IDLE;
            end else begin
               state_d = STAGE_RESULT_VALID;
            end
         end
         default: begin
            state_d = STAGE_IDLE;
         end
      endcase
   end

   // Stage and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= STAGE_IDLE;
         dur_q     <= {DUR_W{1'b0}};
         iter_q    <= {ITER_WIDTH{1'b0}};
         cycle_q   <= {CYCLE_WIDTH{1'b0}};
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dur_q     <= dur_d;
         iter_q    <= iter_d;
         cycle_q   <= cycle_d;
         timeout_q <= timeout_d;
      end
   end

   assign global_stage    = state_q;
   assign new_round_ready = (state_q == STAGE_IDLE);
   assign result_valid    = (state_q == STAGE_RESULT_VALID);
   assign iteration_count = iter_q;
   assign cycle_count     = cycle_q;
   assign timeout         = timeout_q;

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Table-driven rounds with a result scoreboard, plus result-hold and mid-round reset sequences.
module tb_decoder_stage_controller;
   import decoder_stage_controller_pkg::*;

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic                   new_round_valid = 1'b0;
   logic                   new_round_ready;
   logic [STAGE_WIDTH-1:0] global_stage;
   logic                   busy = 1'b0;
   logic                   odd_clusters = 1'b0;
   logic                   result_valid;
   logic                   result_ready = 1'b0;
   logic [7:0]             iteration_count;
   logic [15:0]            cycle_count;
   logic                   timeout;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int         odd_n;
      logic [7:0] busy_mask;
      int         exp_iter;
      int         exp_cycle;
      int         exp_to;
   } vec_t;

   typedef struct {
      int iter;
      int cyc;
      int to;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[6];

   decoder_stage_controller #(.MAX_ITERATIONS(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .new_round_valid(new_round_valid),
      .new_round_ready(new_round_ready),
      .global_stage   (global_stage),
      .busy           (busy),
      .odd_clusters   (odd_clusters),
      .result_valid   (result_valid),
      .result_ready   (result_ready),
      .iteration_count(iteration_count),
      .cycle_count    (cycle_count),
      .timeout        (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_round(input vec_t v, input int hold);
      exp_t e;
      logic [STAGE_WIDTH-1:0] st;
      logic [STAGE_WIDTH-1:0] prev_st;
      int merge_idx = -1;
      int merge_cyc = 0;
      int grows = 0;
      int active = 0;
      bit first_seen = 1'b0;
      bit done = 1'b0;
      e.iter = v.exp_iter;
      e.cyc  = v.exp_cycle;
      e.to   = v.exp_to;
      sb_q.push_back(e);
      prev_st = STAGE_IDLE;
      new_round_valid = 1'b1;
      for (int c = 0; c < 500 && !done; c++) begin
         @(negedge clk);
         st = global_stage;
         if (st != STAGE_IDLE) new_round_valid = 1'b0;
         if (!first_seen && st != STAGE_IDLE) begin
            first_seen = 1'b1;
            check("first_stage_load", st, STAGE_MEASUREMENT_LOADING);
         end
         if (st == STAGE_MERGE && prev_st != STAGE_MERGE) begin
            merge_idx++;
            merge_cyc = 0;
         end else if (st == STAGE_MERGE) begin
            merge_cyc++;
         end
         busy = (st == STAGE_MERGE && merge_idx == 0 && merge_cyc < 8) ? v.busy_mask[merge_cyc] : 1'b0;
         odd_clusters = (merge_idx < v.odd_n);
         if (st == STAGE_GROW) grows++;
         if (st inside {STAGE_MEASUREMENT_LOADING, STAGE_MERGE, STAGE_GROW, STAGE_PEELING}) active++;
         if (st == STAGE_RESULT_VALID) begin
            done = 1'b1;
            e = sb_q.pop_front();
            check("result_valid", result_valid, 1'b1);
            check("iteration_count", iteration_count, e.iter);
            check("cycle_count", cycle_count, e.cyc);
            check("timeout", timeout, e.to);
            check("grow_cycles_seen", grows, e.iter);
            check("active_cycles_seen", active, e.cyc);
         end
         prev_st = st;
      end
      if (!done) begin
         check("round_completed", 1'b0, 1'b1);
         return;
      end
      for (int h = 0; h < hold; h++) begin
         new_round_valid = 1'b1;
         @(negedge clk);
         check("hold_stage", global_stage, STAGE_RESULT_VALID);
         check("hold_ready_low", new_round_ready, 1'b0);
         check("hold_iter", iteration_count, e.iter);
         check("hold_cycle", cycle_count, e.cyc);
         check("hold_timeout", timeout, e.to);
      end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check("after_result_idle", global_stage, STAGE_IDLE);
      if (hold > 0) begin
         @(negedge clk);
         check("idle_then_load", global_stage, STAGE_MEASUREMENT_LOADING);
      end
   endtask

   initial begin
      vecs[0] = '{odd_n: 0,   busy_mask: 8'h00, exp_iter: 0, exp_cycle: 7,  exp_to: 0};
      vecs[1] = '{odd_n: 2,   busy_mask: 8'h00, exp_iter: 2, exp_cycle: 13, exp_to: 0};
      vecs[2] = '{odd_n: 0,   busy_mask: 8'h07, exp_iter: 0, exp_cycle: 10, exp_to: 0};
      vecs[3] = '{odd_n: 0,   busy_mask: 8'h02, exp_iter: 0, exp_cycle: 9,  exp_to: 0};
      vecs[4] = '{odd_n: 100, busy_mask: 8'h00, exp_iter: 4, exp_cycle: 19, exp_to: 1};
      vecs[5] = '{odd_n: 1,   busy_mask: 8'h07, exp_iter: 1, exp_cycle: 13, exp_to: 0};

      #12;
      check("rst_stage", global_stage, STAGE_IDLE);
      check("rst_ready", new_round_ready, 1'b1);
      check("rst_result_valid", result_valid, 1'b0);
      check("rst_iter", iteration_count, 8'd0);
      check("rst_cycle", cycle_count, 16'd0);
      check("rst_timeout", timeout, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_round(vecs[i], 0);
         @(negedge clk);
      end

      run_round(vecs[0], 10);

      // A round is now loading; steer it into GROW and reset mid-cycle.
      new_round_valid = 1'b0;
      busy = 1'b0;
      odd_clusters = 1'b1;
      begin
         bit hit = 1'b0;
         for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            if (global_stage == STAGE_GROW) hit = 1'b1;
         end
         check("reached_grow", hit, 1'b1);
      end
      #2 reset = 1'b0;
      #1;
      check("midreset_stage", global_stage, STAGE_IDLE);
      check("midreset_iter", iteration_count, 8'd0);
      check("midreset_cycle", cycle_count, 16'd0);
      check("midreset_ready", new_round_ready, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      odd_clusters = 1'b0;
      @(negedge clk);
      run_round(vecs[1], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
